// File: rtl/register_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// default sizes plus the grant-selection and one-hot decode helpers.
package register_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;
    localparam int MAX_REQ     = 32;
    localparam int IDX_MAX_W   = 5;

    // Search req from ptr upwards, wrapping at n; only the first set bit is granted.
    function automatic logic [MAX_REQ-1:0] rr_select(input logic [MAX_REQ-1:0] req,
                                                     input int ptr,
                                                     input int n);
        logic [MAX_REQ-1:0]   g;
        logic                 found;
        int                   idx;
        logic [IDX_MAX_W-1:0] pos;
        g     = {MAX_REQ{1'b0}};
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ((ptr + k) >= n) ? (ptr + k - n) : (ptr + k);
            pos = IDX_MAX_W'(idx);
            if ((k < n) && !found && req[pos]) begin
                g[pos] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = {IDX_MAX_W{1'b0}};
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = idx | (oh[i] ? IDX_MAX_W'(i) : {IDX_MAX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/register_write_arbiter_reg.sv
// Plain enable register used as the shared write target; clears on
// asynchronous reset and loads in when en is high.
module register_write_arbiter_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Storage element with load enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= {WIDTH{1'b0}};
        end else if (en) begin
            out <= in;
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing one enable register among NUM_REQ writers;
// tracks last writer, a sticky valid flag and a saturating write count.
module register_write_arbiter
    import register_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_REQ-1:0]                                  req,
    input  logic [NUM_REQ*WIDTH-1:0]                            data,
    output logic [NUM_REQ-1:0]                                  gnt,
    output logic [WIDTH-1:0]                                    out,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]    owner,
    output logic                                                out_valid,
    output logic [CNT_WIDTH-1:0]                                write_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [MAX_REQ-1:0]   req_ext_s;
    logic [MAX_REQ-1:0]   gnt_ext_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [IDX_MAX_W-1:0] gnt_idx_full_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic [IDX_W-1:0]     ptr_next_s;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     owner_r;
    logic [WIDTH-1:0]     sel_data_s;
    logic                 wr_en_s;
    logic                 out_valid_r;
    logic [CNT_WIDTH-1:0] write_count_r;
    logic                 unused_bits_s;

    // Grant selection, grant index, next pointer and data mux
    always_comb begin
        req_ext_s                = {MAX_REQ{1'b0}};
        req_ext_s[NUM_REQ-1:0]   = req;
        gnt_ext_s                = rr_select(req_ext_s, int'(ptr_r), NUM_REQ);
        gnt_s                    = rst ? {NUM_REQ{1'b0}} : gnt_ext_s[NUM_REQ-1:0];
        wr_en_s                  = |gnt_s;
        gnt_idx_full_s           = onehot_to_idx(gnt_ext_s);
        gnt_idx_s                = gnt_idx_full_s[IDX_W-1:0];
        if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
            ptr_next_s = {IDX_W{1'b0}};
        end else begin
            ptr_next_s = gnt_idx_s + IDX_W'(1'b1);
        end
        // AND-OR mux: ungranted slices can never reach the register
        sel_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = sel_data_s | ({WIDTH{gnt_s[i]}} & data[i*WIDTH +: WIDTH]);
        end
        unused_bits_s = ^{gnt_ext_s, gnt_idx_full_s};
    end

    // Pointer, owner, sticky valid and saturating counter updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r         <= {IDX_W{1'b0}};
            owner_r       <= {IDX_W{1'b0}};
            out_valid_r   <= 1'b0;
            write_count_r <= {CNT_WIDTH{1'b0}};
        end else if (wr_en_s) begin
            ptr_r       <= ptr_next_s;
            owner_r     <= gnt_idx_s;
            out_valid_r <= 1'b1;
            if (write_count_r != {CNT_WIDTH{1'b1}}) begin
                write_count_r <= write_count_r + CNT_WIDTH'(1'b1);
            end
        end
    end

    register_write_arbiter_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (wr_en_s),
        .in  (sel_data_s),
        .out (out)
    );

    assign gnt         = gnt_s;
    assign owner       = owner_r;
    assign out_valid   = out_valid_r;
    assign write_count = write_count_r;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Randomized and directed bench for register_write_arbiter against a
// round-robin reference model; a second 3-bit-counter instance checks saturation.
module tb_register_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  dout;
    logic [1:0]  owner;
    logic        out_valid;
    logic [15:0] write_count;
    logic [3:0]  s_gnt;
    logic [7:0]  s_dout;
    logic [1:0]  s_owner;
    logic        s_out_valid;
    logic [2:0]  s_write_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_out, m_owner, m_valid, m_count, m_sat, m_ptr;

    register_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .out(dout),
        .owner(owner), .out_valid(out_valid), .write_count(write_count)
    );

    register_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(s_gnt), .out(s_dout),
        .owner(s_owner), .out_valid(s_out_valid), .write_count(s_write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_req:  assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == 4'd0);
    a_idle:     assert property (@(posedge clk) disable iff (rst) (gnt == 4'd0) |=> $stable(dout));
    a_rst_zero: assert property (@(posedge clk) rst |-> (dout == 8'd0));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_grant(input logic [3:0] r);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (r[i]) return 4'(1 << i);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_out = 0; m_owner = 0; m_valid = 0; m_count = 0; m_sat = 0; m_ptr = 0;
    endtask

    task automatic model_write(input logic [3:0] g, input logic [31:0] d);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        m_out   = int'(d[idx*8 +: 8]);
        m_owner = idx;
        m_valid = 1;
        m_count = (m_count < 65535) ? m_count + 1 : 65535;
        m_sat   = (m_sat < 7) ? m_sat + 1 : 7;
        m_ptr   = (idx + 1) % 4;
    endtask

    task automatic check_outputs();
        check_val("out",         32'(dout),          32'(m_out));
        check_val("owner",       32'(owner),         32'(m_owner));
        check_val("out_valid",   32'(out_valid),     32'(m_valid));
        check_val("write_count", 32'(write_count),   32'(m_count));
        check_val("sat_count",   32'(s_write_count), 32'(m_sat));
    endtask

    // One cycle: drive at negedge, check gnt, let the edge happen, check registers
    task automatic step(input logic [3:0] r, input logic [31:0] d);
        logic [3:0] eg;
        req  = r;
        data = d;
        #1;
        eg = rst ? 4'd0 : model_grant(r);
        check_val("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        if (rst) model_reset();
        else if (eg != 4'd0) model_write(eg, d);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, limit %0d ns", 1_000_000);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] eg;
        rst  = 1'b1;
        req  = 4'd0;
        data = 32'd0;
        model_reset();
        @(negedge clk);

        for (int c = 0; c < 5; c++) step(4'b1111, 32'h13121110);
        rst = 1'b0;

        step(4'b0100, 32'h00A50000);
        step(4'b1000, 32'h77000000);
        for (int c = 0; c < 8; c++) step(4'b1111, 32'h13121110);

        step(4'b0100, 32'h00550000);
        step(4'b0011, 32'h0000BBAA);
        step(4'b0011, 32'h0000BBAA);
        for (int c = 0; c < 3; c++) step(4'b0001, 32'h000000C0 + 32'(c));

        step(4'b0001, 32'h0000003C);
        for (int c = 0; c < 20; c++) step(4'b0000, $urandom());

        for (int c = 0; c < 200; c++) step(4'($urandom_range(0, 15)), $urandom());

        req  = 4'b1111;
        data = 32'h44332211;
        #1;
        eg = model_grant(req);
        @(posedge clk);
        model_write(eg, data);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("gnt_in_reset", 32'(gnt), 32'd0);
        check_outputs();
        @(negedge clk);
        step(4'b1111, 32'h44332211);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) step(4'b1111, $urandom());
        for (int c = 0; c < 40; c++) step(4'($urandom_range(0, 15)), $urandom());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
